// File: rtl/ppc_types.sv
// ppc_types: shared condition-register field and value types for the CR writeback path
package ppc_types;
    typedef logic [0:2] cr_field_t;
    typedef logic [0:3] cr_value_t;
    localparam int CR_FIELDS = 8;
endpackage

// File: rtl/cr_writeback_unit_fifo.sv
// cr_result_fifo: ready/valid result buffer; head data is forced to zero while empty
module cr_result_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push, pop;
    assign in_ready  = cnt_q != FULL_CNT;
    assign out_valid = cnt_q != '0;
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop) cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end
    // storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data;
    end
endmodule

// File: rtl/cr_writeback_unit.sv
// cr_writeback_unit: buffers compare results, owns CR with busy/tag status, broadcasts on CR cdb (optional CR_LOOKUP_FWD_EN forwards a matching broadcast into lookup)
module cr_writeback_unit
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RS_ID_WIDTH-1:0] in_rs_id,
    input  logic [2:0]             in_field,
    input  logic [3:0]             in_result,
    input  logic                   reserve_valid,
    input  logic [2:0]             reserve_field,
    input  logic [RS_ID_WIDTH-1:0] reserve_rs_id,
    input  logic [2:0]             lookup_field,
    output logic                   lookup_valid,
    output logic [3:0]             lookup_value,
    output logic [RS_ID_WIDTH-1:0] lookup_rs_id,
    output logic                   cdb_valid,
    input  logic                   cdb_ready,
    output logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    output logic [2:0]             cdb_field,
    output logic [3:0]             cdb_value,
    output logic [31:0]            cr_out
);
    typedef logic [RS_ID_WIDTH-1:0] rs_id_t;
    typedef struct packed {
        rs_id_t    rs_id;
        cr_field_t field;
        cr_value_t value;
    } cr_wb_entry_t;
    cr_wb_entry_t in_entry, head;
    logic [CR_FIELDS-1:0][3:0] cr_q;
    logic [CR_FIELDS-1:0]      busy_q;
    rs_id_t [CR_FIELDS-1:0]    tag_q;
    logic                      pop;
    assign in_entry  = '{rs_id: in_rs_id, field: in_field, value: in_result};
    assign cdb_rs_id = head.rs_id;
    assign cdb_field = head.field;
    assign cdb_value = head.value;
    assign cr_out    = cr_q;
    assign pop       = cdb_valid && cdb_ready;
    cr_result_fifo #(.W($bits(cr_wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (cdb_valid),
        .out_ready (cdb_ready),
        .out_data  (head)
    );
    // retire writes CR; a reserve issued later in the block wins over a same-field busy clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_q   <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            if (pop) begin
                cr_q[head.field] <= head.value;
                if (tag_q[head.field] == head.rs_id) busy_q[head.field] <= 1'b0;
            end
            if (reserve_valid) begin
                busy_q[reserve_field] <= 1'b1;
                tag_q[reserve_field]  <= reserve_rs_id;
            end
        end
    end
    // dispatch operand query from registered state, optionally bypassing the current broadcast
    always_comb begin
        lookup_valid = !busy_q[lookup_field];
        lookup_value = cr_q[lookup_field];
        lookup_rs_id = tag_q[lookup_field];
`ifdef CR_LOOKUP_FWD_EN
        if (pop && cdb_field == lookup_field && tag_q[lookup_field] == cdb_rs_id) begin
            lookup_valid = 1'b1;
            lookup_value = cdb_value;
        end
`endif
    end
endmodule
